// File: rtl/systolic_result_drain.sv
// rtl/systolic_result_drain.sv - de-skews systolic array column outputs into result vectors and streams them from a FIFO
// Lanes arrive staggered by column index; a triangular delay line realigns them before the FIFO write.
module systolic_result_drain #(
  parameter int COL_NUM    = 32,
  parameter int DW         = 32,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [COL_NUM*DW-1:0]        col_in_flat,
  input  logic                         in_valid,
  output logic                         m_valid,
  input  logic                         m_ready,
  output logic [COL_NUM*DW-1:0]        m_data,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic                         ovf,
  input  logic                         clr_ovf,
  output logic [15:0]                  vec_cnt
);

  localparam int VW = COL_NUM * DW;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] FULL_LVL = LW'(FIFO_DEPTH);

  logic [COL_NUM-2:0] vpipe_q;
  logic [COL_NUM-2:0] vpipe_d;
  logic [VW-1:0]      aligned;

  logic [VW-1:0]      mem_q [FIFO_DEPTH];
  logic [AW-1:0]      wr_ptr_q;
  logic [AW-1:0]      wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q;
  logic [AW-1:0]      rd_ptr_d;
  logic [LW-1:0]      level_q;
  logic [LW-1:0]      level_d;
  logic               ovf_q;
  logic               ovf_d;
  logic [15:0]        vec_cnt_q;
  logic [15:0]        vec_cnt_d;

  logic               push;
  logic               pop;
  logic               full;
  logic               empty;
  logic               push_ok;
  logic               drop;

  // Lane j waits COL_NUM-1-j cycles so every lane lines up with the raw last lane.
  for (genvar j = 0; j < COL_NUM - 1; j++) begin : g_lane
    localparam int D = COL_NUM - 1 - j;
    logic [DW-1:0] sr_q [D];

    always_ff @(posedge clk) begin
      sr_q[0] <= col_in_flat[DW*j +: DW];
      for (int s = 1; s < D; s++) begin
        sr_q[s] <= sr_q[s-1];
      end
    end

    assign aligned[DW*j +: DW] = sr_q[D-1];
  end

  assign aligned[DW*(COL_NUM-1) +: DW] = col_in_flat[DW*(COL_NUM-1) +: DW];

  always_comb begin
    vpipe_d    = '0;
    vpipe_d[0] = in_valid;
    for (int i = 1; i < COL_NUM - 1; i++) begin
      vpipe_d[i] = vpipe_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vpipe_q <= '0;
    end else begin
      vpipe_q <= vpipe_d;
    end
  end

  assign push    = vpipe_q[COL_NUM-2];
  assign empty   = (level_q == '0);
  assign full    = (level_q == FULL_LVL);
  assign pop     = !empty && m_ready;
  // A pop on the same edge frees the slot the incoming vector needs.
  assign push_ok = push && (!full || pop);
  assign drop    = push && full && !pop;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    ovf_d     = ovf_q;
    vec_cnt_d = vec_cnt_q;

    if (push_ok) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + AW'(1);
      vec_cnt_d = vec_cnt_q + 16'd1;
    end

    case ({push_ok, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase

    if (drop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      ovf_q     <= 1'b0;
      vec_cnt_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      ovf_q     <= ovf_d;
      vec_cnt_q <= vec_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= aligned;
    end
  end

  assign m_valid    = !empty;
  assign m_data     = mem_q[rd_ptr_q];
  assign fifo_level = level_q;
  assign ovf        = ovf_q;
  assign vec_cnt    = vec_cnt_q;

endmodule

// File: tb/tb_systolic_result_drain.sv
// tb/tb_systolic_result_drain.sv - scoreboard bench for systolic_result_drain
// Drives skewed column data, queues expected vectors at issue, checks every head vector seen.
module tb_systolic_result_drain;

  localparam int N  = 32;
  localparam int DW = 32;
  localparam int VW = N * DW;

  typedef logic [VW-1:0] vec_t;

  logic        clk;
  logic        rst;
  vec_t        col_in_flat;
  logic        in_valid;
  logic        m_valid;
  logic        m_ready;
  vec_t        m_data;
  logic [3:0]  fifo_level;
  logic        ovf;
  logic        clr_ovf;
  logic [15:0] vec_cnt;

  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t exp_q [$];
  vec_t hist [N];
  int   lat;

  systolic_result_drain #(.COL_NUM(N), .DW(DW), .FIFO_DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .col_in_flat (col_in_flat),
    .in_valid    (in_valid),
    .m_valid     (m_valid),
    .m_ready     (m_ready),
    .m_data      (m_data),
    .fifo_level  (fifo_level),
    .ovf         (ovf),
    .clr_ovf     (clr_ovf),
    .vec_cnt     (vec_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_vec(input string tag, input vec_t obs, input vec_t exp);
    int lane;
    lane = 0;
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      for (int j = N - 1; j >= 0; j--) begin
        if (obs[DW*j +: DW] !== exp[DW*j +: DW]) lane = j;
      end
      $error("FAIL %s lane=%0d observed=%0h expected=%0h", tag, lane,
             obs[DW*lane +: DW], exp[DW*lane +: DW]);
    end
  endtask

  function automatic vec_t rand_vec();
    vec_t v;
    for (int j = 0; j < N; j++) v[DW*j +: DW] = $urandom;
    return v;
  endfunction

  function automatic vec_t mk(input int k);
    vec_t v;
    for (int j = 0; j < N; j++) v[DW*j +: DW] = 32'(100 * k + j);
    return v;
  endfunction

  function automatic vec_t pat(input int k);
    vec_t v;
    for (int j = 0; j < N; j++) v[DW*j +: DW] = ((j + k) % 2 == 1) ? 32'hFFFF_FFFF : 32'h8000_0000;
    return v;
  endfunction

  // hist[j] is the vector issued j steps ago; lane j of the bus carries hist[j]'s lane j.
  task automatic step(input logic v, input vec_t vec, input logic exp_push);
    @(posedge clk);
    #1;
    for (int j = N - 1; j > 0; j--) hist[j] = hist[j-1];
    hist[0]  = v ? vec : rand_vec();
    in_valid = v;
    for (int j = 0; j < N; j++) col_in_flat[DW*j +: DW] = hist[j][DW*j +: DW];
    if (v && exp_push) exp_q.push_back(vec);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (!rst && m_valid) begin
      chk("valid_has_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        chk_vec("m_data", m_data, exp_q[0]);
        if (m_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    in_valid    = 1'b0;
    m_ready     = 1'b0;
    clr_ovf     = 1'b0;
    col_in_flat = '0;
    for (int j = 0; j < N; j++) hist[j] = rand_vec();
    idle(3);
    rst = 1'b0;
    chk("rst_m_valid", m_valid, 0);
    chk_vec("rst_m_data", m_data, '0);
    chk("rst_level", fifo_level, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_vec_cnt", vec_cnt, 0);

    // single vector latency
    m_ready = 1'b1;
    begin
      vec_t v1;
      for (int j = 0; j < N; j++) v1[DW*j +: DW] = 32'(j + 1);
      step(1'b1, v1, 1'b1);
    end
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1'b0, '0, 1'b0);
      if (m_valid && lat < 0) lat = i - 1;
    end
    chk("t1_latency", lat, 31);
    chk("t1_vec_cnt", vec_cnt, 1);
    chk("t1_drained", exp_q.size(), 0);

    // burst of 8 into a stalled FIFO
    m_ready = 1'b0;
    for (int k = 0; k < 8; k++) step(1'b1, mk(k), 1'b1);
    idle(33);
    chk("t2_level_full", fifo_level, 8);
    chk("t2_ovf", ovf, 0);
    m_ready = 1'b1;
    idle(10);
    chk("t2_drained", exp_q.size(), 0);
    chk("t2_vec_cnt", vec_cnt, 9);
    chk("t2_level_empty", fifo_level, 0);

    // overflow, clear, push+pop while full, set-wins
    m_ready = 1'b0;
    for (int k = 8; k < 16; k++) step(1'b1, mk(k), 1'b1);
    step(1'b1, mk(16), 1'b0);
    idle(33);
    chk("t3_ovf_set", ovf, 1);
    chk("t3_level_after_drop", fifo_level, 8);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    chk("t3_ovf_cleared", ovf, 0);
    step(1'b1, mk(20), 1'b1);
    idle(31);
    m_ready = 1'b1;
    idle(1);
    m_ready = 1'b0;
    idle(2);
    chk("t3_level_push_pop_full", fifo_level, 8);
    chk("t3_no_drop", ovf, 0);
    step(1'b1, mk(21), 1'b0);
    idle(31);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    idle(1);
    chk("t3_set_wins", ovf, 1);
    chk("t3_level_set_wins", fifo_level, 8);
    clr_ovf = 1'b1;
    idle(1);
    clr_ovf = 1'b0;
    m_ready = 1'b1;
    idle(12);
    chk("t3_drained", exp_q.size(), 0);
    chk("t3_vec_cnt", vec_cnt, 18);
    chk("t3_ovf_final", ovf, 0);

    // steady stream against a toggling m_ready
    m_ready = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step(1'b1, mk(200 + k), 1'b1);
      m_ready = ~m_ready;
      step(1'b0, '0, 1'b0);
      m_ready = ~m_ready;
    end
    for (int i = 0; i < 60; i++) begin
      step(1'b0, '0, 1'b0);
      m_ready = ~m_ready;
    end
    m_ready = 1'b1;
    idle(2);
    chk("t4_drained", exp_q.size(), 0);
    chk("t4_ovf", ovf, 0);
    chk("t4_vec_cnt", vec_cnt, 38);
    chk("t4_level", fifo_level, 0);

    // reset with vectors buffered and in flight
    m_ready = 1'b0;
    for (int k = 0; k < 3; k++) step(1'b1, mk(300 + k), 1'b1);
    idle(33);
    chk("t5_level_before", fifo_level, 3);
    for (int k = 0; k < 5; k++) step(1'b1, mk(310 + k), 1'b1);
    idle(2);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    exp_q.delete();
    chk("t5_m_valid", m_valid, 0);
    chk("t5_level", fifo_level, 0);
    m_ready = 1'b1;
    idle(45);
    chk("t5_m_valid_later", m_valid, 0);
    chk("t5_vec_cnt", vec_cnt, 0);

    // extreme lane values with gaps, vec_cnt wrap
    for (int k = 0; k < 65530; k++) step(1'b1, rand_vec(), 1'b1);
    idle(34);
    chk("t6_vec_cnt_pre", vec_cnt, 16'hFFFA);
    for (int k = 0; k < 8; k++) begin
      step(1'b1, pat(k), 1'b1);
      idle(3);
    end
    idle(35);
    chk("t6_vec_cnt_wrap", vec_cnt, 2);
    chk("t6_drained", exp_q.size(), 0);
    chk("t6_ovf", ovf, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
